// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } burst_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Command, stream, monitor and response bundle for the FIFO burst reader.
// The slave modport is the reader itself; master is the environment around it.
interface fifo_burst_reader_if
  import fifo_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int GAP_W = 4
);

  logic              cmd_vld;
  logic              cmd_rdy;
  logic [LEN_W-1:0]  cmd_len;
  logic [GAP_W-1:0]  cmd_gap;

  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic              in_rdy;

  logic              mon_vld;
  logic [DATA_W-1:0] mon_data;

  logic              rsp_vld;
  logic              rsp_rdy;
  logic [DATA_W-1:0] rsp_sum;
  logic [LEN_W-1:0]  rsp_cnt;

  modport master (
    output cmd_vld, cmd_len, cmd_gap, in_data, in_vld, rsp_rdy,
    input  cmd_rdy, in_rdy, mon_vld, mon_data, rsp_vld, rsp_sum, rsp_cnt
  );

  modport slave (
    input  cmd_vld, cmd_len, cmd_gap, in_data, in_vld, rsp_rdy,
    output cmd_rdy, in_rdy, mon_vld, mon_data, rsp_vld, rsp_sum, rsp_cnt
  );

endinterface

// File: rtl/fifo_burst_reader.sv
// Drain-side burst reader: pops a commanded number of words from a
// valid/ready stream with an optional idle gap between pops, sums them
// modulo 2^32 and returns the sum and word count as a response.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int GAP_W = 4
) (
  input logic               clk,
  input logic               rstB,
  fifo_burst_reader_if.slave bus
);

  burst_state_t      state;
  burst_state_t      next_state;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_inc;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] sum_q;

  logic              pop;
  logic              last_pop;

  // Termination compares count+1 against len, so the counter never wraps
  // even for the maximum burst length.
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign last_pop = (cnt_inc == len_q);
  assign pop      = bus.in_vld && (state == READ);

  assign bus.mon_vld  = bus.in_vld && bus.in_rdy;
  assign bus.mon_data = bus.in_data;
  assign bus.rsp_sum  = sum_q;
  assign bus.rsp_cnt  = cnt_q;

  // State register; reset abandons any burst in flight without a response.
  always_ff @(posedge clk) begin
    if (!rstB) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode; ready/valid outputs depend on state only.
  always_comb begin
    next_state  = state;
    bus.cmd_rdy = 1'b0;
    bus.in_rdy  = 1'b0;
    bus.rsp_vld = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_rdy = 1'b1;
        if (bus.cmd_vld) begin
          next_state = (bus.cmd_len == '0) ? RESP : READ;
        end
      end
      READ: begin
        bus.in_rdy = 1'b1;
        if (bus.in_vld) begin
          if (last_pop) begin
            next_state = RESP;
          end else if (gap_q != '0) begin
            next_state = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          next_state = READ;
        end
      end
      RESP: begin
        bus.rsp_vld = 1'b1;
        if (bus.rsp_rdy) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Burst datapath: command latch, running sum, word count and gap counter.
  always_ff @(posedge clk) begin
    if (!rstB) begin
      len_q   <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_vld) begin
            len_q <= bus.cmd_len;
            gap_q <= bus.cmd_gap;
            cnt_q <= '0;
            sum_q <= '0;
          end
        end
        READ: begin
          if (pop) begin
            sum_q <= sum_q + bus.in_data;
            cnt_q <= cnt_inc;
            if (!last_pop && (gap_q != '0)) begin
              gap_cnt <= gap_q;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
